// File: rtl/axi4_lite_master_seq.sv
// Single-outstanding AXI4-Lite master: command/response port in, one
// AXI4-Lite transaction out, with a watchdog on the B/R response phases.
//
// Ports
//   iCLK, iRST            clock, asynchronous active-low reset
//   cmd_*                 command request (valid/ready), write/addr/wdata/wstrb
//   rsp_*                 response (valid/ready), resp code and read data
//   err_count             saturating count of non-OKAY responses
//   m_AW*/m_W*/m_B*       AXI4-Lite write channels
//   m_AR*/m_R*            AXI4-Lite read channels
module axi4_lite_master_seq #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [2:0]  PROT    = 3'b000
) (
    input  logic        iCLK,
    input  logic        iRST,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  err_count,

    output logic        m_AWVALID,
    input  logic        m_AWREADY,
    output logic [31:0] m_AWADDR,
    output logic [2:0]  m_AWPROT,

    output logic        m_WVALID,
    input  logic        m_WREADY,
    output logic [31:0] m_WDATA,
    output logic [3:0]  m_WSTRB,

    input  logic        m_BVALID,
    output logic        m_BREADY,
    input  logic [1:0]  m_BRESP,

    output logic        m_ARVALID,
    input  logic        m_ARREADY,
    output logic [31:0] m_ARADDR,
    output logic [2:0]  m_ARPROT,

    input  logic        m_RVALID,
    output logic        m_RREADY,
    input  logic [31:0] m_RDATA,
    input  logic [1:0]  m_RRESP
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RESP,
        S_DRAIN_B,
        S_DRAIN_R
    } state_t;

    state_t        state_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          write_q;
    logic          aw_valid_q;
    logic          w_valid_q;
    logic          ar_valid_q;
    logic          bready_q;
    logic          rready_q;
    logic          rsp_valid_q;
    logic [1:0]    rsp_resp_q;
    logic [31:0]   rsp_rdata_q;
    logic [7:0]    err_count_q;
    logic [TW-1:0] timer_q;
    logic          timed_out_q;

    logic          aw_done;
    logic          w_done;
    logic          waddr_fin;
    logic          resp_hs;
    logic          tmo;
    logic [1:0]    resp_in;
    logic [31:0]   rdata_in;
    logic          err_new;

    assign aw_done   = aw_valid_q & m_AWREADY;
    assign w_done    = w_valid_q & m_WREADY;
    // A channel is finished if it handshakes now or already did earlier.
    assign waddr_fin = (aw_done | ~aw_valid_q) & (w_done | ~w_valid_q);

    always_comb begin
        resp_hs  = 1'b0;
        resp_in  = 2'b00;
        rdata_in = '0;
        if (state_q == S_WRESP) begin
            resp_hs = m_BVALID;
            resp_in = m_BRESP;
        end else if (state_q == S_RDATA) begin
            resp_hs  = m_RVALID;
            resp_in  = m_RRESP;
            rdata_in = m_RDATA;
        end
    end

    // Counter starts at 0 in the first response-phase cycle, so the
    // timeout fires after TIMEOUT+1 cycles without a handshake.
    assign tmo     = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));
    assign err_new = resp_hs ? (resp_in != 2'b00) : 1'b1;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
            timer_q     <= '0;
            timed_out_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        write_q <= cmd_write;
                        if (cmd_write) begin
                            state_q    <= S_WADDR;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                        end else begin
                            state_q    <= S_RADDR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end

                S_WADDR: begin
                    if (aw_done) aw_valid_q <= 1'b0;
                    if (w_done)  w_valid_q  <= 1'b0;
                    if (waddr_fin) begin
                        state_q  <= S_WRESP;
                        bready_q <= 1'b1;
                        timer_q  <= '0;
                    end
                end

                S_RADDR: begin
                    if (m_ARREADY) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= S_RDATA;
                        rready_q   <= 1'b1;
                        timer_q    <= '0;
                    end
                end

                S_WRESP, S_RDATA: begin
                    if (resp_hs) begin
                        rsp_resp_q  <= resp_in;
                        rsp_rdata_q <= rdata_in;
                        timed_out_q <= 1'b0;
                    end else if (tmo) begin
                        rsp_resp_q  <= 2'b11;
                        rsp_rdata_q <= '0;
                        timed_out_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if (resp_hs || tmo) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        if (err_new && (err_count_q != 8'hFF))
                            err_count_q <= err_count_q + 8'd1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (!timed_out_q) begin
                            state_q <= S_IDLE;
                        end else if (write_q) begin
                            state_q  <= S_DRAIN_B;
                            bready_q <= 1'b1;
                        end else begin
                            state_q  <= S_DRAIN_R;
                            rready_q <= 1'b1;
                        end
                    end
                end

                // The slave still owes one beat; swallow it silently.
                S_DRAIN_B: begin
                    if (m_BVALID) begin
                        bready_q    <= 1'b0;
                        timed_out_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                S_DRAIN_R: begin
                    if (m_RVALID) begin
                        rready_q    <= 1'b0;
                        timed_out_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_rdata = rsp_rdata_q;
    assign err_count = err_count_q;

    assign m_AWVALID = aw_valid_q;
    assign m_AWADDR  = addr_q;
    assign m_AWPROT  = PROT;
    assign m_WVALID  = w_valid_q;
    assign m_WDATA   = wdata_q;
    assign m_WSTRB   = wstrb_q;
    assign m_BREADY  = bready_q;
    assign m_ARVALID = ar_valid_q;
    assign m_ARADDR  = addr_q;
    assign m_ARPROT  = PROT;
    assign m_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_seq.sv
// Directed bench for axi4_lite_master_seq with a reactive AXI4-Lite
// memory slave model, a vector table and hand-written corner sequences.
module tb_axi4_lite_master_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;

    logic        m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY;
    logic [31:0] m_AWADDR, m_WDATA, m_ARADDR;
    logic [2:0]  m_AWPROT, m_ARPROT;
    logic [3:0]  m_WSTRB;
    logic        m_AWREADY = 1'b0;
    logic        m_WREADY = 1'b0;
    logic        m_ARREADY = 1'b0;
    logic        m_BVALID = 1'b0;
    logic [1:0]  m_BRESP = 2'b00;
    logic        m_RVALID = 1'b0;
    logic [31:0] m_RDATA = '0;
    logic [1:0]  m_RRESP = 2'b00;

    axi4_lite_master_seq #(
        .TIMEOUT(8),
        .PROT   (3'b010)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_resp (rsp_resp),
        .rsp_rdata(rsp_rdata),
        .err_count(err_count),
        .m_AWVALID(m_AWVALID),
        .m_AWREADY(m_AWREADY),
        .m_AWADDR (m_AWADDR),
        .m_AWPROT (m_AWPROT),
        .m_WVALID (m_WVALID),
        .m_WREADY (m_WREADY),
        .m_WDATA  (m_WDATA),
        .m_WSTRB  (m_WSTRB),
        .m_BVALID (m_BVALID),
        .m_BREADY (m_BREADY),
        .m_BRESP  (m_BRESP),
        .m_ARVALID(m_ARVALID),
        .m_ARREADY(m_ARREADY),
        .m_ARADDR (m_ARADDR),
        .m_ARPROT (m_ARPROT),
        .m_RVALID (m_RVALID),
        .m_RREADY (m_RREADY),
        .m_RDATA  (m_RDATA),
        .m_RRESP  (m_RRESP)
    );

    always #5 clk = ~clk;

    // slave configuration, written by the main sequence
    int       cfg_aw_dly = 0;
    int       cfg_w_dly = 0;
    int       cfg_ar_dly = 0;
    int       cfg_rsp_dly = 0;
    logic [1:0] cfg_resp = 2'b00;
    bit       cfg_hang = 1'b0;

    // slave state and statistics
    int       aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int       proto_err = 0;
    int       aw_age = 0, w_age = 0, ar_age = 0, b_wait = 0, r_wait = 0;
    bit       aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    bit       p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
    bit       p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
    logic [31:0] sl_waddr = '0, sl_wdata = '0, sl_raddr = '0;
    logic [3:0]  sl_wstrb = '0;
    logic [31:0] mem [256];

    // Slave runs on the falling edge: it first books the handshakes of
    // the rising edge just passed, then drives its inputs for the next one.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_AWREADY = 0; m_WREADY = 0; m_ARREADY = 0;
            m_BVALID = 0; m_BRESP = 0;
            m_RVALID = 0; m_RDATA = 0; m_RRESP = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_age = 0; w_age = 0; ar_age = 0; b_wait = 0; r_wait = 0;
            p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0;
            p_br = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
            for (int i = 0; i < 256; i++) mem[i] = '0;
        end else begin
            if (p_awv && !p_awr && !m_AWVALID) proto_err++;
            if (p_wv && !p_wr && !m_WVALID) proto_err++;
            if (p_arv && !p_arr && !m_ARVALID) proto_err++;
            if (m_ARVALID && (m_AWVALID || m_WVALID)) proto_err++;

            if (p_awv && p_awr) begin
                aw_cnt++; aw_got = 1; sl_waddr = m_AWADDR;
            end
            if (p_wv && p_wr) begin
                w_cnt++; w_got = 1; sl_wdata = m_WDATA; sl_wstrb = m_WSTRB;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                if (cfg_resp == 2'b00)
                    for (int i = 0; i < 4; i++)
                        if (sl_wstrb[i])
                            mem[sl_waddr[9:2]][i*8 +: 8] = sl_wdata[i*8 +: 8];
                b_pend = 1; b_wait = cfg_rsp_dly;
            end
            if (p_bv && p_br) begin b_cnt++; m_BVALID = 0; end
            if (p_arv && p_arr) begin
                ar_cnt++; r_pend = 1; r_wait = cfg_rsp_dly; sl_raddr = m_ARADDR;
            end
            if (p_rv && p_rr) begin r_cnt++; m_RVALID = 0; end

            if (b_pend && !cfg_hang) begin
                if (b_wait == 0) begin
                    m_BVALID = 1; m_BRESP = cfg_resp; b_pend = 0;
                end else b_wait--;
            end
            if (r_pend && !cfg_hang) begin
                if (r_wait == 0) begin
                    m_RVALID = 1; m_RRESP = cfg_resp;
                    m_RDATA = mem[sl_raddr[9:2]]; r_pend = 0;
                end else r_wait--;
            end

            m_AWREADY = m_AWVALID && (aw_age >= cfg_aw_dly);
            aw_age = m_AWVALID ? aw_age + 1 : 0;
            m_WREADY = m_WVALID && (w_age >= cfg_w_dly);
            w_age = m_WVALID ? w_age + 1 : 0;
            m_ARREADY = m_ARVALID && (ar_age >= cfg_ar_dly);
            ar_age = m_ARVALID ? ar_age + 1 : 0;

            p_awv = m_AWVALID; p_awr = m_AWREADY;
            p_wv = m_WVALID; p_wr = m_WREADY;
            p_bv = m_BVALID; p_br = m_BREADY;
            p_arv = m_ARVALID; p_arr = m_ARREADY;
            p_rv = m_RVALID; p_rr = m_RREADY;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly;
        int          w_dly;
        int          rsp_dly;
        logic [1:0]  sresp;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic wait_idle(input string name);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk({name, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input string name);
        int lat, aw0, w0, b0, ar0, r0;
        cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly;
        cfg_ar_dly = v.aw_dly; cfg_rsp_dly = v.rsp_dly;
        cfg_resp = v.sresp; cfg_hang = 0;
        wait_idle(name);
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
        cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(name, lat);
        chk({name, "_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        chk({name, "_rdata"}, rsp_rdata, v.exp_rdata);
        chk({name, "_err"}, 32'(err_count), 32'(v.exp_err));
        if (v.exp_lat >= 0) chk({name, "_lat"}, 32'(lat), 32'(v.exp_lat));
        @(negedge clk);
        chk({name, "_ready_back"}, 32'(cmd_ready), 32'd1);
        chk({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        if (v.wr) begin
            chk({name, "_aw_n"}, 32'(aw_cnt - aw0), 32'd1);
            chk({name, "_w_n"}, 32'(w_cnt - w0), 32'd1);
            chk({name, "_b_n"}, 32'(b_cnt - b0), 32'd1);
            chk({name, "_ar_n"}, 32'(ar_cnt - ar0), 32'd0);
        end else begin
            chk({name, "_ar_n"}, 32'(ar_cnt - ar0), 32'd1);
            chk({name, "_r_n"}, 32'(r_cnt - r0), 32'd1);
            chk({name, "_aw_n"}, 32'(aw_cnt - aw0), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int lat, r0, bad;
        bit saw_rsp;
        vec_t v;

        //          wr  addr       wdata         strb  awd wd rd sresp eresp erdata        eerr lat
        vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1, 0, 2'd0, 2'd0, 32'h0,        8'd0, 4};
        vecs[1] = '{0, 32'h10, 32'h0,        4'h0, 1, 0, 0, 2'd0, 2'd0, 32'hDEADBEEF, 8'd0, 4};
        vecs[2] = '{1, 32'h14, 32'h12345678, 4'h5, 0, 3, 0, 2'd0, 2'd0, 32'h0,        8'd0, 6};
        vecs[3] = '{0, 32'h14, 32'h0,        4'h0, 0, 0, 0, 2'd0, 2'd0, 32'h00340078, 8'd0, -1};
        vecs[4] = '{1, 32'h20, 32'hCAFEF00D, 4'hF, 0, 0, 0, 2'd2, 2'd2, 32'h0,        8'd1, -1};
        vecs[5] = '{0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 2'd3, 2'd3, 32'h0,        8'd2, -1};
        vecs[6] = '{0, 32'h10, 32'h0,        4'h0, 0, 0, 4, 2'd0, 2'd0, 32'hDEADBEEF, 8'd2, -1};
        vecs[7] = '{1, 32'h24, 32'hA5A5A5A5, 4'hF, 2, 0, 0, 2'd0, 2'd0, 32'h0,        8'd2, -1};
        vecs[8] = '{0, 32'h24, 32'h0,        4'h0, 0, 0, 0, 2'd0, 2'd0, 32'hA5A5A5A5, 8'd2, -1};

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_awvalid", 32'(m_AWVALID), 32'd0);
        chk("rst_arvalid", 32'(m_ARVALID), 32'd0);
        chk("rst_bready", 32'(m_BREADY), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("awprot", 32'(m_AWPROT), 32'd2);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        // read against a slave that never answers: timeout, then drain
        cfg_ar_dly = 0; cfg_rsp_dly = 0; cfg_resp = 2'b00; cfg_hang = 1;
        wait_idle("tmo");
        cmd_write = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("tmo", lat);
        chk("tmo_lat", 32'(lat), 32'd11);
        chk("tmo_resp", 32'(rsp_resp), 32'd3);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        chk("tmo_err", 32'(err_count), 32'd3);
        @(negedge clk);
        chk("drain_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("drain_rready", 32'(m_RREADY), 32'd1);
        repeat (3) @(negedge clk);
        chk("drain_hold", 32'(cmd_ready), 32'd0);
        r0 = r_cnt;
        cfg_hang = 0;
        saw_rsp = 0;
        for (int n = 0; n < 20 && !cmd_ready; n++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
        end
        chk("drain_done", 32'(cmd_ready), 32'd1);
        chk("drain_no_rsp", 32'(saw_rsp), 32'd0);
        chk("drain_err", 32'(err_count), 32'd3);
        @(negedge clk);
        chk("drain_r_n", 32'(r_cnt - r0), 32'd1);

        // back-pressure on the response port with a queued command
        rsp_ready = 1'b0;
        wait_idle("bp");
        cmd_write = 1'b0; cmd_addr = 32'h24; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_addr = 32'h10;
        wait_rsp("bp", lat);
        chk("bp_rdata", rsp_rdata, 32'hA5A5A5A5);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== 32'hA5A5A5A5 || cmd_ready) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("bp2", lat);
        chk("bp2_rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // asynchronous reset while W is waiting for WREADY
        cfg_aw_dly = 0; cfg_w_dly = 20; cfg_rsp_dly = 0; cfg_resp = 2'b00;
        wait_idle("arst");
        cmd_write = 1'b1; cmd_addr = 32'h30;
        cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("arst_wvalid_pre", 32'(m_WVALID), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_awvalid", 32'(m_AWVALID), 32'd0);
        chk("arst_wvalid", 32'(m_WVALID), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_err", 32'(err_count), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_awaddr", m_AWADDR, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1, 32'h30, 32'h0BADF00D, 4'hF, 1, 1, 0, 2'd0, 2'd0, 32'h0, 8'd0, 4};
        run_txn(v, "post_w");
        v = '{0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 2'd0, 2'd0, 32'h0BADF00D, 8'd0, -1};
        run_txn(v, "post_r");

        chk("protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_seq.md
# axi4_lite_master_seq

Single-outstanding AXI4-Lite master sequencer that turns a simple command/response interface into complete AXI4-Lite write or read transactions toward one AXI4-Lite slave (e.g. the on-chip 256-word memory slave). It issues AW and W together, waits for B or R, returns the result on a response port, and guards the response phases with a watchdog so a hung slave cannot stall the requester. It sits between a local controller (test sequencer, CPU bridge) and the AXI4-Lite fabric.

## Interface

- TIMEOUT, 64: response-phase watchdog limit in cycles; 0 disables the watchdog.
- PROT, 3'b000: constant value driven on m_AWPROT and m_ARPROT.
- iCLK  in  1  clock. One clock domain; all logic on the rising edge.
- iRST  in  1  reset. Asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle; command accepted on cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  transaction address.
- cmd_wdata  in  32  write data; ignored for reads.
- cmd_wstrb  in  4  write strobes; ignored for reads.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  requester accepts the response.
- rsp_resp  out  2  BRESP/RRESP from the slave, or 2'b11 on timeout.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- err_count  out  8  saturating count of responses with rsp_resp != 2'b00.
- m_AWVALID/m_AWADDR/m_AWPROT  out  1/32/3  write address; m_AWREADY  in  1.
- m_WVALID/m_WDATA/m_WSTRB  out  1/32/4  write data; m_WREADY  in  1.
- m_BVALID/m_BRESP  in  1/2  write response; m_BREADY  out  1.
- m_ARVALID/m_ARADDR/m_ARPROT  out  1/32/3  read address; m_ARREADY  in  1.
- m_RVALID/m_RDATA/m_RRESP  in  1/32/2  read data; m_RREADY  out  1.

## Operation

- States: IDLE, WADDR, WRESP, RADDR, RDATA, RESP, DRAIN_B, DRAIN_R.
- IDLE: cmd_ready=1. On accept, latch addr, wdata, wstrb and write. Go to WADDR if write, otherwise RADDR.
- WADDR: m_AWVALID and m_WVALID are both asserted in the first cycle of the state. Each drops independently on its own handshake. Neither is withdrawn before its handshake, and there is no timeout in this state. Leave for WRESP when both handshakes are done; same-cycle completion is allowed.
- RADDR: m_ARVALID=1 until the handshake, then go to RDATA.
- WRESP/RDATA: m_BREADY / m_RREADY is driven high for the entire state, independent of the slave's VALID, because the slave's VALID may pulse for a single cycle. On the handshake, latch resp (and rdata for reads) and go to RESP.
- Watchdog: the cycle counter clears on entry to WRESP/RDATA. If no handshake has occurred by the TIMEOUT-th cycle in the state:
  - latch rsp_resp=2'b11 and rsp_rdata=0;
  - go to RESP, then to DRAIN_B/DRAIN_R instead of IDLE.
- RESP: rsp_valid=1. On rsp_ready, go to IDLE, or to DRAIN_x after a timeout.
- DRAIN_B/DRAIN_R: m_BREADY / m_RREADY is held high and cmd_ready=0. The first late B/R handshake is discarded, then go to IDLE.
- err_count increments once per RESP entry with a non-OKAY resp and saturates at 255.
- Outputs are registered. cmd_ready is a decode of the state register.

## Timing

- Reset (asynchronous, while iRST=0):
  - state=IDLE and cmd_ready=1;
  - all m_*VALID, m_BREADY, m_RREADY and rsp_valid are 0;
  - rsp_resp=0, rsp_rdata=0, err_count=0, address/data registers 0.
- Reset asserted mid-transaction aborts immediately to the reset values. There is no drain after a reset.
- Cycle 0: command accept edge. Cycle 1: AW/W (or AR) VALID high.
- rsp_valid rises the cycle after the B/R handshake. cmd_ready rises the cycle after the rsp handshake (or after the drain handshake).
- Against a slave with 1-cycle READY and a next-cycle response:
  - handshakes complete at cycles 2 and 3;
  - rsp_valid is high at cycle 4;
  - with rsp_ready=1, a new command can be accepted at cycle 5.
- Exactly one transaction is outstanding; a read and a write never overlap.
- Timeout response appears TIMEOUT+1 cycles after entry to WRESP/RDATA.

## Test plan

- Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, slave OKAY -> one AW and one W handshake, BREADY high, rsp_resp=2'b00, rsp_rdata=0, err_count=0.
- Read addr=0x10 after that write -> one AR handshake, rsp_rdata=0xDEADBEEF, rsp_resp=2'b00.
- Slave raises AWREADY 3 cycles before WREADY -> m_AWVALID drops after its handshake, m_WVALID stays high until WREADY, and exactly one B is consumed.
- Read with a slave that never asserts RVALID, TIMEOUT=8 -> rsp_resp=2'b11 at cycle 9 after RDATA entry, err_count=1. A late RVALID is then drained and not reported, and cmd_ready returns.
- rsp_ready held low for 5 cycles, with cmd_valid held high -> rsp_valid and rsp_rdata remain stable and cmd_ready stays 0 until the rsp handshake.
- iRST pulsed low while m_WVALID=1 -> all outputs reach reset values asynchronously. The next command after release completes normally.
